// File: rtl/fifo_pkg.sv
// Shared types and defaults for the async-FIFO read-side burst consumer.
package fifo_pkg;

  localparam int FIFO_DSIZE     = 8;
  localparam int FIFO_LSIZE     = 8;
  localparam int FIFO_TO_CYCLES = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } rd_state_t;

  typedef struct packed {
    logic [FIFO_DSIZE-1:0] data;
    logic                  last;
  } buf_entry_t;

endpackage

// File: rtl/fifo_out_buf.sv
// Two-entry valid/ready skid buffer of {data, last}; set_last tags the youngest entry.
module fifo_out_buf #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          push_last,
  input  logic          pop,
  input  logic          set_last,
  output logic [DW-1:0] head_data,
  output logic          head_last,
  output logic [1:0]    count
);

  logic [DW-1:0] data_reg [2];
  logic          last_reg [2];
  logic          wr_ptr_reg;
  logic          rd_ptr_reg;
  logic [1:0]    count_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_entry
      localparam logic IDX = 1'(gi);
      // With two slots the youngest entry is always the one wr_ptr is not pointing at.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          data_reg[gi] <= '0;
          last_reg[gi] <= 1'b0;
        end else if (push && wr_ptr_reg == IDX) begin
          data_reg[gi] <= push_data;
          last_reg[gi] <= push_last;
        end else if (set_last && count_reg != 2'd0 && wr_ptr_reg != IDX) begin
          last_reg[gi] <= 1'b1;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (push) wr_ptr_reg <= ~wr_ptr_reg;
      if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 2'd1;
        2'b01:   count_reg <= count_reg - 2'd1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign head_data = data_reg[rd_ptr_reg];
  assign head_last = last_reg[rd_ptr_reg];
  assign count     = count_reg;

endmodule

// File: rtl/fifo_burst_reader.sv
// Drains burst_len words from a FWFT FIFO onto a valid/ready stream with m_last.
// Optional stall timeout is enabled by defining FIFO_RD_TIMEOUT_EN.
module fifo_burst_reader
  import fifo_pkg::*;
#(
  parameter int DSIZE     = FIFO_DSIZE,
  parameter int LSIZE     = FIFO_LSIZE,
  parameter int TO_CYCLES = FIFO_TO_CYCLES
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic             start,
  input  logic [LSIZE-1:0] burst_len,
  output logic             busy,
  output logic             done,
  output logic             rinc,
  input  logic [DSIZE-1:0] rdata,
  input  logic             rempty,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [DSIZE-1:0] m_data,
  output logic             m_last,
  output logic             timeout
);

  rd_state_t        state_reg, state_next;
  logic [LSIZE-1:0] remaining_reg, remaining_next;
  logic [1:0]       count;
  logic             pop;
  logic             to_fire;

  // rinc depends only on registered state and rempty, never on m_ready.
  assign rinc    = (state_reg == RUN) && !rempty && (remaining_reg != '0) && (count != 2'd2);
  assign m_valid = (count != 2'd0);
  assign pop     = m_valid && m_ready;
  assign busy    = (state_reg != IDLE);
  assign done    = (state_reg == DONE);

  fifo_out_buf #(.DW(DSIZE)) u_out_buf (
    .clk       (rclk),
    .rst_n     (rrst_n),
    .push      (rinc),
    .push_data (rdata),
    .push_last (remaining_reg == LSIZE'(1)),
    .pop       (pop),
    .set_last  (to_fire),
    .head_data (m_data),
    .head_last (m_last),
    .count     (count)
  );

`ifdef FIFO_RD_TIMEOUT_EN
  localparam int TW = $clog2(TO_CYCLES + 1);

  logic [TW-1:0] idle_cnt_reg, idle_cnt_next;
  logic          timeout_reg, timeout_next;

  assign to_fire = (state_reg == RUN) && (remaining_reg != '0) && rempty &&
                   (idle_cnt_reg == TW'(TO_CYCLES - 1));

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      idle_cnt_reg <= '0;
      timeout_reg  <= 1'b0;
    end else begin
      idle_cnt_reg <= idle_cnt_next;
      timeout_reg  <= timeout_next;
    end
  end

  always_comb begin
    idle_cnt_next = idle_cnt_reg;
    timeout_next  = timeout_reg;
    if (state_reg != RUN || rinc || to_fire) begin
      idle_cnt_next = '0;
    end else if (remaining_reg != '0 && rempty) begin
      idle_cnt_next = idle_cnt_reg + TW'(1);
    end
    if (state_reg == IDLE && start) begin
      timeout_next = 1'b0;
    end else if (to_fire) begin
      timeout_next = 1'b1;
    end
  end

  assign timeout = timeout_reg;
`else
  wire [31:0] unused_to_cycles = TO_CYCLES;
  assign to_fire = 1'b0;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state_reg     <= IDLE;
      remaining_reg <= '0;
    end else begin
      state_reg     <= state_next;
      remaining_reg <= remaining_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    remaining_next = remaining_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          if (burst_len != '0) begin
            remaining_next = burst_len;
            state_next     = RUN;
          end else begin
            state_next = DONE;
          end
        end
      end
      RUN: begin
        if (rinc) remaining_next = remaining_reg - LSIZE'(1);
        if (pop && m_last) state_next = DONE;
        // Abort: if nothing will be left buffered to carry the last flag, finish now.
        if (to_fire) begin
          remaining_next = '0;
          if (count == 2'd0 || (count == 2'd1 && pop)) state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Scoreboard bench for fifo_burst_reader against a behavioural FWFT FIFO model.
`timescale 1ns/1ps
module tb_fifo_burst_reader;
  import fifo_pkg::*;

  logic       rclk = 1'b0;
  logic       rrst_n = 1'b1;
  logic       start = 1'b0;
  logic [7:0] burst_len = 8'd0;
  logic       busy, done, rinc, m_valid, m_last, timeout;
  logic [7:0] m_data;
  logic [7:0] rdata = 8'h00;
  logic       rempty = 1'b1;
  logic       m_ready = 1'b0;

  always #5 rclk = ~rclk;

  fifo_burst_reader #(.DSIZE(8), .LSIZE(8), .TO_CYCLES(16)) dut (
    .rclk(rclk), .rrst_n(rrst_n), .start(start), .burst_len(burst_len),
    .busy(busy), .done(done), .rinc(rinc), .rdata(rdata), .rempty(rempty),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .timeout(timeout)
  );

  // FWFT FIFO model
  logic [7:0] fq[$];
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;

  always @(posedge rclk) begin
    if (rinc && fq.size() != 0) void'(fq.pop_front());
    if (wr_en) fq.push_back(wr_data);
    rempty <= (fq.size() == 0);
    rdata  <= (fq.size() != 0) ? fq[0] : 8'h00;
  end

  // Scoreboard
  buf_entry_t exp_q[$];
  buf_entry_t e;
  int   checks = 0, failures = 0, done_cnt = 0, rinc_cnt = 0;
  logic last_xfer_prev = 1'b0, stall_prev = 1'b0, zero_ok = 1'b0;
  logic [7:0] held_data = 8'h00;
  logic       held_last = 1'b0;

  always @(negedge rclk) begin
    if (!rrst_n) begin
      last_xfer_prev = 1'b0;
      stall_prev     = 1'b0;
    end else begin
      if (rinc) begin
        checks++; rinc_cnt++;
        if (rempty) begin failures++; $display("FAIL rinc_while_empty actual=1 required=0"); end
      end
      if (stall_prev) begin
        checks++;
        if (m_valid !== 1'b1 || m_data !== held_data || m_last !== held_last) begin
          failures++;
          $display("FAIL stall_hold actual=%0b/%02h/%0b required=1/%02h/%0b",
                   m_valid, m_data, m_last, held_data, held_last);
        end
      end
      if (m_valid && m_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_word actual=%02h/%0b required=none", m_data, m_last);
        end else begin
          e = exp_q.pop_front();
          $display("xfer data=%02h last=%0b", m_data, m_last);
          if (m_data !== e.data || m_last !== e.last) begin
            failures++;
            $display("FAIL word actual=%02h/%0b required=%02h/%0b", m_data, m_last, e.data, e.last);
          end
        end
      end
      if (done) begin
        checks++; done_cnt++;
        if (!(last_xfer_prev || zero_ok)) begin
          failures++; $display("FAIL done_timing actual=1 required=0");
        end
        zero_ok = 1'b0;
      end else if (last_xfer_prev) begin
        checks++; failures++;
        $display("FAIL done_after_last actual=0 required=1");
      end
      last_xfer_prev = m_valid && m_ready && m_last;
      stall_prev     = m_valid && !m_ready;
      held_data      = m_data;
      held_last      = m_last;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge rclk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic write_word(input logic [7:0] d);
    wr_data = d; wr_en = 1'b1;
    tick(1);
    wr_en = 1'b0;
  endtask

  task automatic expect_word(input logic [7:0] d, input logic l);
    exp_q.push_back('{data: d, last: l});
  endtask

  task automatic start_burst(input logic [7:0] len);
    burst_len = len; start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget);
    int n = 0;
    while (done_cnt < target && n < budget) begin tick(1); n++; end
    check("done_count", done_cnt, target);
  endtask

`ifdef FIFO_RD_TIMEOUT_EN
  localparam int W2_CYCLE = 20;
`else
  localparam int W2_CYCLE = 30;
`endif

  int dn = 0;
  int r0;

  initial begin
    // Reset state
    #2 rrst_n = 1'b0;
    #1;
    check("rst_busy", busy, 0);   check("rst_done", done, 0);
    check("rst_rinc", rinc, 0);   check("rst_m_valid", m_valid, 0);
    check("rst_m_last", m_last, 0); check("rst_m_data", m_data, 0);
    check("rst_timeout", timeout, 0);
    tick(2);
    rrst_n = 1'b1;
    tick(1);

    // T1: five preloaded words, back-to-back
    for (int i = 0; i < 5; i++) write_word(8'h11 + 8'(i));
    tick(1);
    m_ready = 1'b1;
    for (int i = 0; i < 5; i++) expect_word(8'h11 + 8'(i), i == 4);
    r0 = rinc_cnt;
    start_burst(8'd5);
    dn++; wait_done(dn, 50);
    check("t1_fifo_left", fq.size(), 0);
    check("t1_rinc_cnt", rinc_cnt - r0, 5);
    check("t1_busy_idle", busy, 0);

    // T2: partial drain of eight words
    for (int i = 0; i < 8; i++) write_word(8'h20 + 8'(i));
    tick(1);
    for (int i = 0; i < 3; i++) expect_word(8'h20 + 8'(i), i == 2);
    r0 = rinc_cnt;
    start_burst(8'd3);
    dn++; wait_done(dn, 50);
    check("t2_fifo_left", fq.size(), 5);
    check("t2_rinc_cnt", rinc_cnt - r0, 3);
    check("t2_rempty", rempty, 0);
    fq.delete();
    tick(2);

    // T3: m_ready toggling 1,0,0
    for (int i = 0; i < 4; i++) write_word(8'h30 + 8'(i));
    tick(1);
    for (int i = 0; i < 4; i++) expect_word(8'h30 + 8'(i), i == 3);
    start_burst(8'd4);
    dn++;
    for (int i = 0; i < 60 && done_cnt < dn; i++) begin
      m_ready = (i % 3 == 0);
      tick(1);
    end
    m_ready = 1'b1;
    check("t3_done_count", done_cnt, dn);
    check("t3_fifo_left", fq.size(), 0);

    // T4: empty FIFO, words arrive late
    expect_word(8'hA5, 1'b0);
    expect_word(8'h5A, 1'b1);
    start_burst(8'd2);
    for (int i = 0; i < 40 && done_cnt < dn + 1; i++) begin
      if (i == 10)            begin wr_data = 8'hA5; wr_en = 1'b1; end
      else if (i == W2_CYCLE) begin wr_data = 8'h5A; wr_en = 1'b1; end
      else wr_en = 1'b0;
      if (i == 15) begin
        check("t4_busy_stall", busy, 1);
        check("t4_no_timeout", timeout, 0);
      end
      tick(1);
    end
    wr_en = 1'b0;
    dn++; wait_done(dn, 20);

    // T5: zero-length burst, then start ignored during RUN
    r0 = rinc_cnt;
    zero_ok = 1'b1;
    start_burst(8'd0);
    check("t5_done_pulse", done, 1);
    check("t5_no_valid", m_valid, 0);
    dn++; wait_done(dn, 5);
    check("t5_no_rinc", rinc_cnt - r0, 0);
    expect_word(8'h40, 1'b0);
    expect_word(8'h41, 1'b1);
    start_burst(8'd2);
    tick(3);
    start_burst(8'd7);
    for (int i = 0; i < 3; i++) write_word(8'h40 + 8'(i));
    dn++; wait_done(dn, 60);
    tick(3);
    check("t5_ignored_start", done_cnt, dn);
    check("t5_fifo_left", fq.size(), 1);
    fq.delete();
    tick(2);

`ifdef FIFO_RD_TIMEOUT_EN
    // T6: timeout with only two of four words available
    m_ready = 1'b0;
    write_word(8'h50); write_word(8'h51);
    tick(1);
    expect_word(8'h50, 1'b0);
    expect_word(8'h51, 1'b1);
    start_burst(8'd4);
    tick(30);
    check("t6_timeout", timeout, 1);
    check("t6_busy", busy, 1);
    m_ready = 1'b1;
    dn++; wait_done(dn, 20);
    check("t6_timeout_sticky", timeout, 1);
    zero_ok = 1'b1;
    start_burst(8'd0);
    check("t6_timeout_clear", timeout, 0);
    dn++; wait_done(dn, 5);
`endif

    // T7: reset mid-burst drops buffered words
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) write_word(8'h60 + 8'(i));
    tick(1);
    start_burst(8'd4);
    tick(3);
    check("t7_valid_before", m_valid, 1);
    #2 rrst_n = 1'b0;
    #1;
    check("t7_rst_valid", m_valid, 0);
    check("t7_rst_busy", busy, 0);
    check("t7_rst_data", m_data, 0);
    check("t7_rst_last", m_last, 0);
    check("t7_rst_rinc", rinc, 0);
    tick(1);
    rrst_n = 1'b1;
    m_ready = 1'b1;
    tick(5);
    check("t7_no_done", done_cnt, dn);
    check("t7_fifo_left", fq.size(), 2);

    check("exp_q_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
